// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared encodings and field positions for the decode stage
package decode_pkg;

  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  localparam int RS_LSB = 8;
  localparam int RT_LSB = 5;
  localparam int RD_LSB = 2;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_RS   = 2'b10,
    DST_LINK = 2'b11
  } regdst_e;

  typedef enum logic [1:0] {
    IMM5    = 2'b00,
    IMM8    = 2'b01,
    IMM11   = 2'b10,
    IMM_ILL = 2'b11
  } imm_size_e;

endpackage

// File: rtl/rf_bypass.sv
// rtl/rf_bypass.sv - 8-entry register file, two read ports, one write port with write-through bypass
module rf_bypass
  import decode_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [WIDTH-1:0]  rdata1_o,
  output logic [WIDTH-1:0]  rdata2_o
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A same-cycle writeback wins over the stored value so ID sees it without waiting a cycle.
  assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage_p.sv
// rtl/decode_stage_p.sv - decode stage with RF bypass, immediate gen, load-use interlock and ID/EX register
// Optional counters enabled by DECODE_STAGE_PERF_EN.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CTRL_W   = 12,
  parameter int LINK_REG = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr_IFID,
  input  logic              valid_IFID,
  input  logic [WIDTH-1:0]  PC_IFID,
  input  logic [WIDTH-1:0]  PC2_IFID,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              RegWrite_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              rd1_used,
  input  logic              rd2_used,
  input  logic [1:0]        RegDst,
  input  logic [1:0]        size,
  input  logic              zeroEx,
  input  logic              stall_ext,
  input  logic              flush,
  input  logic              RegWrite_MEMWB,
  input  logic [2:0]        WrR_MEMWB,
  input  logic [WIDTH-1:0]  writeData,
  output logic              stall_IFID,
  output logic              valid_IDEX,
  output logic              RegWrite_IDEX,
  output logic              MemRead_IDEX,
  output logic              MemWrite_IDEX,
  output logic [CTRL_W-1:0] ctrl_IDEX,
  output logic [WIDTH-1:0]  PC_IDEX,
  output logic [WIDTH-1:0]  PC2_IDEX,
  output logic [WIDTH-1:0]  Rd1_IDEX,
  output logic [WIDTH-1:0]  Rd2_IDEX,
  output logic [WIDTH-1:0]  Imm_IDEX,
  output logic [2:0]        Rd1Addr_IDEX,
  output logic [2:0]        Rd2Addr_IDEX,
  output logic [2:0]        WrR_IDEX,
  output logic              err
`ifdef DECODE_STAGE_PERF_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  logic [REG_AW-1:0] rs, rt, rd, wrr_sel;
  logic              we;
  logic              load_use;
  logic              bubble;
  logic [WIDTH-1:0]  rd1_val, rd2_val, imm_val;
  imm_size_e         size_e;
  regdst_e           dst_e;
  logic              unused_instr_bits;

  logic              valid_q, valid_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  pc2_q, pc2_d;
  logic [WIDTH-1:0]  rd1_q, rd1_d;
  logic [WIDTH-1:0]  rd2_q, rd2_d;
  logic [WIDTH-1:0]  imm_q, imm_d;
  logic [2:0]        a1_q, a1_d;
  logic [2:0]        a2_q, a2_d;
  logic [2:0]        wrr_q, wrr_d;

  assign rs = instr_IFID[RS_LSB +: REG_AW];
  assign rt = instr_IFID[RT_LSB +: REG_AW];
  assign rd = instr_IFID[RD_LSB +: REG_AW];
  assign unused_instr_bits = ^instr_IFID[15:11];

  assign we = RegWrite_MEMWB & ~stall_ext;

  rf_bypass #(.WIDTH(WIDTH)) u_rf (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (we),
    .waddr_i  (WrR_MEMWB),
    .wdata_i  (writeData),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rd1_val),
    .rdata2_o (rd2_val)
  );

  assign size_e = imm_size_e'(size);
  assign dst_e  = regdst_e'(RegDst);

  always_comb begin
    imm_val = '0;
    case (size_e)
      IMM5:    imm_val = zeroEx ? {{(WIDTH-5){1'b0}}, instr_IFID[4:0]}
                                : {{(WIDTH-5){instr_IFID[4]}}, instr_IFID[4:0]};
      IMM8:    imm_val = zeroEx ? {{(WIDTH-8){1'b0}}, instr_IFID[7:0]}
                                : {{(WIDTH-8){instr_IFID[7]}}, instr_IFID[7:0]};
      IMM11:   imm_val = zeroEx ? {{(WIDTH-11){1'b0}}, instr_IFID[10:0]}
                                : {{(WIDTH-11){instr_IFID[10]}}, instr_IFID[10:0]};
      default: imm_val = '0;
    endcase
  end

  assign err = valid_IFID & (size_e == IMM_ILL);

  always_comb begin
    wrr_sel = rt;
    case (dst_e)
      DST_RT:   wrr_sel = rt;
      DST_RD:   wrr_sel = rd;
      DST_RS:   wrr_sel = rs;
      DST_LINK: wrr_sel = REG_AW'(LINK_REG);
      default:  wrr_sel = rt;
    endcase
  end

  // Only a valid load that writes a register can leave a consumer waiting on memory data.
  assign load_use = valid_q & mr_q & rw_q & valid_IFID &
                    ((rd1_used & (rs == wrr_q)) | (rd2_used & (rt == wrr_q)));

  assign stall_IFID = load_use & ~flush & ~stall_ext;
  assign bubble     = flush | load_use;

  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    pc2_d   = pc2_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    wrr_d   = wrr_q;
    if (!stall_ext) begin
      pc_d    = PC_IFID;
      pc2_d   = PC2_IFID;
      rd1_d   = rd1_val;
      rd2_d   = rd2_val;
      imm_d   = imm_val;
      a1_d    = rs;
      a2_d    = rt;
      wrr_d   = wrr_sel;
      valid_d = valid_IFID & ~bubble;
      rw_d    = RegWrite_in & valid_IFID & ~bubble;
      mr_d    = MemRead_in & valid_IFID & ~bubble;
      mw_d    = MemWrite_in & valid_IFID & ~bubble;
      ctrl_d  = bubble ? '0 : ctrl_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      pc2_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      wrr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      pc2_q   <= pc2_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      wrr_q   <= wrr_d;
    end
  end

  assign valid_IDEX    = valid_q;
  assign RegWrite_IDEX = rw_q;
  assign MemRead_IDEX  = mr_q;
  assign MemWrite_IDEX = mw_q;
  assign ctrl_IDEX     = ctrl_q;
  assign PC_IDEX       = pc_q;
  assign PC2_IDEX      = pc2_q;
  assign Rd1_IDEX      = rd1_q;
  assign Rd2_IDEX      = rd2_q;
  assign Imm_IDEX      = imm_q;
  assign Rd1Addr_IDEX  = a1_q;
  assign Rd2Addr_IDEX  = a2_q;
  assign WrR_IDEX      = wrr_q;

`ifdef DECODE_STAGE_PERF_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Flush takes precedence, so a cycle with both is counted only as a flush bubble.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!stall_ext) begin
      if (flush) begin
        if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
      end else if (load_use) begin
        if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage_p.sv
// tb/tb_decode_stage_p.sv - scoreboard bench for decode_stage_p against a behavioural model
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_IFID;
  logic        valid_IFID;
  logic [15:0] PC_IFID, PC2_IFID;
  logic [11:0] ctrl_in;
  logic        RegWrite_in, MemRead_in, MemWrite_in;
  logic        rd1_used, rd2_used;
  logic [1:0]  RegDst, size;
  logic        zeroEx, stall_ext, flush;
  logic        RegWrite_MEMWB;
  logic [2:0]  WrR_MEMWB;
  logic [15:0] writeData;
  logic        stall_IFID, valid_IDEX, RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX;
  logic [11:0] ctrl_IDEX;
  logic [15:0] PC_IDEX, PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX;
  logic [2:0]  Rd1Addr_IDEX, Rd2Addr_IDEX, WrR_IDEX;
  logic        err;
`ifdef DECODE_STAGE_PERF_EN
  logic [15:0] bubble_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  decode_stage_p dut (
    .clk(clk), .rst(rst), .instr_IFID(instr_IFID), .valid_IFID(valid_IFID),
    .PC_IFID(PC_IFID), .PC2_IFID(PC2_IFID), .ctrl_in(ctrl_in),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .rd1_used(rd1_used), .rd2_used(rd2_used), .RegDst(RegDst), .size(size),
    .zeroEx(zeroEx), .stall_ext(stall_ext), .flush(flush),
    .RegWrite_MEMWB(RegWrite_MEMWB), .WrR_MEMWB(WrR_MEMWB), .writeData(writeData),
    .stall_IFID(stall_IFID), .valid_IDEX(valid_IDEX), .RegWrite_IDEX(RegWrite_IDEX),
    .MemRead_IDEX(MemRead_IDEX), .MemWrite_IDEX(MemWrite_IDEX), .ctrl_IDEX(ctrl_IDEX),
    .PC_IDEX(PC_IDEX), .PC2_IDEX(PC2_IDEX), .Rd1_IDEX(Rd1_IDEX), .Rd2_IDEX(Rd2_IDEX),
    .Imm_IDEX(Imm_IDEX), .Rd1Addr_IDEX(Rd1Addr_IDEX), .Rd2Addr_IDEX(Rd2Addr_IDEX),
    .WrR_IDEX(WrR_IDEX), .err(err)
`ifdef DECODE_STAGE_PERF_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic        valid, rw, mr, mw;
    logic [11:0] ctrl;
    logic [15:0] pc, pc2, rd1, rd2, imm;
    logic [2:0]  a1, a2, wr;
    logic        stall, err;
    logic [15:0] bcnt, fcnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  logic [15:0] rf[8];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] imm_model(input logic [15:0] ins, input logic [1:0] sz, input logic zx);
    int bits, val;
    if (sz == 2'd3) return 16'h0000;
    bits = (sz == 2'd0) ? 5 : (sz == 2'd1) ? 8 : 11;
    val  = int'(ins) % (1 << bits);
    if (!zx && val >= (1 << (bits - 1))) val = val + 65536 - (1 << bits);
    return val[15:0];
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
  endtask

  // Record the expectation for the current cycle, then advance the model across the next edge.
  task automatic commit();
    exp_t        e;
    logic [2:0]  rs, rt, rd, dst;
    logic        we, lu, bub, v;
    logic [15:0] r1, r2;
    #1;
    rs = instr_IFID[10:8];
    rt = instr_IFID[7:5];
    rd = instr_IFID[4:2];
    we = RegWrite_MEMWB && !stall_ext;
    r1 = (we && WrR_MEMWB == rs) ? writeData : rf[rs];
    r2 = (we && WrR_MEMWB == rt) ? writeData : rf[rt];
    lu = m.valid && m.mr && m.rw && valid_IFID &&
         ((rd1_used && rs == m.wr) || (rd2_used && rt == m.wr));
    e       = m;
    e.stall = lu && !flush && !stall_ext;
    e.err   = valid_IFID && (size == 2'd3);
    sb.push_back(e);
    if (rst) begin
      model_reset();
    end else if (!stall_ext) begin
      dst = (RegDst == 2'd0) ? rt : (RegDst == 2'd1) ? rd : (RegDst == 2'd2) ? rs : 3'd7;
      bub = flush || lu;
      v   = valid_IFID && !bub;
      m.valid = v;
      m.rw    = RegWrite_in && v;
      m.mr    = MemRead_in && v;
      m.mw    = MemWrite_in && v;
      m.ctrl  = bub ? 12'h0 : ctrl_in;
      m.pc    = PC_IFID;
      m.pc2   = PC2_IFID;
      m.rd1   = r1;
      m.rd2   = r2;
      m.imm   = imm_model(instr_IFID, size, zeroEx);
      m.a1    = rs;
      m.a2    = rt;
      m.wr    = dst;
      if (flush) begin
        if (m.fcnt != 16'hFFFF) m.fcnt = m.fcnt + 16'd1;
      end else if (lu) begin
        if (m.bcnt != 16'hFFFF) m.bcnt = m.bcnt + 16'd1;
      end
      if (we) rf[WrR_MEMWB] = writeData;
    end
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #2;
    rst = 0; instr_IFID = 16'h0; valid_IFID = 0; PC_IFID = 16'h0; PC2_IFID = 16'h0;
    ctrl_in = 12'h0; RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0;
    rd1_used = 0; rd2_used = 0; RegDst = 2'd0; size = 2'd0; zeroEx = 0;
    stall_ext = 0; flush = 0; RegWrite_MEMWB = 0; WrR_MEMWB = 3'd0; writeData = 16'h0;
  endtask

  task automatic rand_cycle();
    begin_cycle();
    rst            = ($urandom_range(0, 99) < 2);
    instr_IFID     = 16'($urandom);
    valid_IFID     = ($urandom_range(0, 9) < 8);
    PC_IFID        = 16'($urandom);
    PC2_IFID       = PC_IFID + 16'd2;
    ctrl_in        = 12'($urandom);
    RegWrite_in    = 1'($urandom);
    MemRead_in     = 1'($urandom);
    MemWrite_in    = 1'($urandom);
    rd1_used       = 1'($urandom);
    rd2_used       = 1'($urandom);
    RegDst         = 2'($urandom);
    size           = 2'($urandom);
    zeroEx         = 1'($urandom);
    stall_ext      = ($urandom_range(0, 9) == 0);
    flush          = ($urandom_range(0, 9) == 0);
    RegWrite_MEMWB = 1'($urandom);
    WrR_MEMWB      = 3'($urandom);
    writeData      = 16'($urandom);
    commit();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("stall_IFID", {15'h0, stall_IFID}, {15'h0, e.stall});
        chk("err", {15'h0, err}, {15'h0, e.err});
        chk("valid_IDEX", {15'h0, valid_IDEX}, {15'h0, e.valid});
        chk("RegWrite_IDEX", {15'h0, RegWrite_IDEX}, {15'h0, e.rw});
        chk("MemRead_IDEX", {15'h0, MemRead_IDEX}, {15'h0, e.mr});
        chk("MemWrite_IDEX", {15'h0, MemWrite_IDEX}, {15'h0, e.mw});
        chk("ctrl_IDEX", {4'h0, ctrl_IDEX}, {4'h0, e.ctrl});
        chk("PC_IDEX", PC_IDEX, e.pc);
        chk("PC2_IDEX", PC2_IDEX, e.pc2);
        chk("Rd1_IDEX", Rd1_IDEX, e.rd1);
        chk("Rd2_IDEX", Rd2_IDEX, e.rd2);
        chk("Imm_IDEX", Imm_IDEX, e.imm);
        chk("Rd1Addr_IDEX", {13'h0, Rd1Addr_IDEX}, {13'h0, e.a1});
        chk("Rd2Addr_IDEX", {13'h0, Rd2Addr_IDEX}, {13'h0, e.a2});
        chk("WrR_IDEX", {13'h0, WrR_IDEX}, {13'h0, e.wr});
`ifdef DECODE_STAGE_PERF_EN
        chk("bubble_cnt", bubble_cnt, e.bcnt);
        chk("flush_cnt", flush_cnt, e.fcnt);
`endif
      end
    end
  end

  initial begin : driver
    rst = 1; instr_IFID = 16'h0; valid_IFID = 0; PC_IFID = 16'h0; PC2_IFID = 16'h0;
    ctrl_in = 12'h0; RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0;
    rd1_used = 0; rd2_used = 0; RegDst = 2'd0; size = 2'd0; zeroEx = 0;
    stall_ext = 0; flush = 0; RegWrite_MEMWB = 0; WrR_MEMWB = 3'd0; writeData = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);

    begin_cycle(); rst = 1; commit();

    // bypass of r3 into Rs, then r3 read from storage
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0300;
    RegWrite_MEMWB = 1; WrR_MEMWB = 3'd3; writeData = 16'h1234; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0360; commit();

    // immediate sign/zero extension and illegal size
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0016; size = 2'd0; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0016; size = 2'd0; zeroEx = 1; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0016; size = 2'd3; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0485; size = 2'd2; commit();

    // load to r2 followed by a consumer of r2, held one cycle by the interlock
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0040; RegWrite_in = 1; MemRead_in = 1;
    ctrl_in = 12'hABC; commit();
    for (int k = 0; k < 2; k++) begin
      begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0200; rd1_used = 1; RegWrite_in = 1;
      ctrl_in = 12'h555; RegDst = 2'd1; commit();
    end

    // load-use coinciding with flush
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0040; RegWrite_in = 1; MemRead_in = 1; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0200; rd1_used = 1; flush = 1;
    ctrl_in = 12'h777; commit();

    // external stall blocks both ID/EX update and the r4 write
    begin_cycle(); RegWrite_MEMWB = 1; WrR_MEMWB = 3'd4; writeData = 16'h1111; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0480; ctrl_in = 12'h123; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0480; stall_ext = 1;
    RegWrite_MEMWB = 1; WrR_MEMWB = 3'd4; writeData = 16'hBEEF; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0480; RegDst = 2'd3; commit();

    // reset while ID/EX is valid, then r5 must read zero
    begin_cycle(); RegWrite_MEMWB = 1; WrR_MEMWB = 3'd5; writeData = 16'h5A5A; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0500; RegWrite_in = 1; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h0500; rst = 1; commit();
    begin_cycle(); valid_IFID = 1; instr_IFID = 16'h05A0; commit();

    for (int n = 0; n < 3000; n++) rand_cycle();

    begin_cycle(); commit();
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
- Parametrised next-generation decode stage: register file with write-through bypass, immediate generation, destination select and the ID/EX pipeline register.
- Adds behaviour the first-generation stage lacks: an explicit valid bit, an internal load-use interlock, a defined stall/flush priority and illegal-size error reporting.
- Sits between IF/ID and EX; the control unit supplies an opaque control bundle that is carried to EX.

Parameters:
- WIDTH, 16, datapath width of registers, PC and immediate.
- CTRL_W, 12, width of opaque control bundle carried to EX.
- LINK_REG, 7, register index written when RegDst=11.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_IFID  in  16  instruction; fixed fields: Rs=[10:8], Rt=[7:5], Rd=[4:2]
- valid_IFID  in  1  IF/ID holds a real instruction
- PC_IFID, PC2_IFID  in  WIDTH  PC and PC+2
- ctrl_in  in  CTRL_W  control bundle from control unit
- RegWrite_in, MemRead_in, MemWrite_in  in  1  hazard-relevant controls
- rd1_used, rd2_used  in  1  instruction reads Rs / Rt
- RegDst, size  in  2  destination select; immediate size
- zeroEx  in  1  zero-extend immediate
- stall_ext  in  1  global hold (memory stall)
- flush  in  1  taken branch/jump resolved downstream
- RegWrite_MEMWB  in  1  writeback enable
- WrR_MEMWB  in  3  writeback register
- writeData  in  WIDTH  writeback data
- stall_IFID  out  1  hold PC and IF/ID (load-use)
- valid_IDEX, RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX  out  1
- ctrl_IDEX  out  CTRL_W
- PC_IDEX, PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX  out  WIDTH
- Rd1Addr_IDEX, Rd2Addr_IDEX, WrR_IDEX  out  3
- err  out  1  illegal immediate size

Behaviour:
- Reset: on rst at a clk edge, every ID/EX output and every RF entry becomes 0. stall_IFID and err are combinational and therefore 0 while valid_IFID=0.
- RF: 8 x WIDTH entries, combinational read, write at clk edge.
  - Effective write enable: we = RegWrite_MEMWB & ~stall_ext.
  - r0 is an ordinary register.
- Bypass: a read port returns writeData when we=1 and the write address equals the read address; otherwise it returns stored data.
- Immediate, extended to WIDTH:
  - size 00 = [4:0], 01 = [7:0], 10 = [10:0].
  - Sign-extend unless zeroEx=1.
  - size 11: Imm=0, err = valid_IFID.
- Destination select: RegDst 00 = Rt, 01 = Rd, 10 = Rs, 11 = LINK_REG.
- load_use = valid_IDEX & MemRead_IDEX & RegWrite_IDEX & valid_IFID & ((rd1_used & Rs==WrR_IDEX) | (rd2_used & Rt==WrR_IDEX)).
- ID/EX update, first match wins:
  - rst: clear.
  - stall_ext: hold all.
  - flush: bubble.
  - load_use: bubble.
  - else load valid_IDEX=valid_IFID and all fields.
- Bubble: valid, RegWrite, MemRead, MemWrite and ctrl_IDEX are 0. Data and address fields are don't-care and are loaded normally.
- Fields loaded with valid_IFID=0 must have RegWrite/MemRead/MemWrite forced to 0.
- stall_IFID = load_use & ~flush & ~stall_ext.
- Latency: one cycle from IF/ID to ID/EX. A load-use costs exactly one bubble, after which the consumer reads the loaded register via EX/MEM forwarding.

Optional Feature:
- Macro: DECODE_STAGE_PERF_EN.
- When defined:
  - Adds outputs bubble_cnt[15:0] and flush_cnt[15:0].
  - Counters increment on each load_use bubble and each flush bubble respectively.
  - They saturate at 16'hFFFF, hold during stall_ext and reset to 0.
- When undefined: the ports and logic are absent and the remaining behaviour is identical.

Decomposition:
- Package decode_pkg:
  - RegDst encodings (DST_RT, DST_RD, DST_RS, DST_LINK).
  - Size encodings (IMM5, IMM8, IMM11, IMM_ILL).
  - Field position constants.
  - Register-address width 3.
- Sub-module rf_bypass: 8 x WIDTH register file, two read ports, one write port, write-through bypass, synchronous reset.

Test Plan:
- Reset mid-stream: rst=1 for one cycle while ID/EX is valid -> next cycle all ID/EX outputs 0; then r5 reads as 0.
- Immediate: instr[4:0]=5'b10110, size=00, zeroEx=0 -> Imm_IDEX=16'hFFF6; same with zeroEx=1 -> 16'h0016; size=11 -> Imm_IDEX=0 and err=1.
- Bypass: RegWrite_MEMWB=1, WrR_MEMWB=3, writeData=16'h1234, IF/ID Rs=3 -> next cycle Rd1_IDEX=16'h1234; r3 then reads 16'h1234.
- Load-use: ID/EX holds a load to r2, IF/ID has Rs=2 with rd1_used=1 -> stall_IFID=1; next cycle valid_IDEX=0 and ctrl_IDEX=0; following cycle the consumer is loaded with valid_IDEX=1.
- Flush with load_use in the same cycle -> stall_IFID=0 and a bubble enters ID/EX; counters (if enabled): flush_cnt+1, bubble_cnt unchanged.
- stall_ext=1 with RegWrite_MEMWB=1 writing r4=16'hBEEF -> ID/EX held unchanged and r4 is not written; after release r4 retains its old value.
